sal_bank_fsm: RTL and testbench

- Per-bank controller and the request side of the command scheduler.
- Takes one queued AXI-derived request at a time and tracks the state of its DRAM bank.
- Raises act/rd/wr/pre/ref requests toward the scheduler and advances its state when the scheduler grants one.
- One instance per bank; `DRAM_BK_CNT` instances feed the scheduler's bank request array.

---
 rtl/sal_bank_fsm.sv | 161 ++++++++++++++++
 tb/tb_sal_bank_fsm.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sal_bank_fsm.sv
// rtl/sal_bank_fsm.sv - per-bank DRAM state machine and scheduler request side
// Optional closed-page policy (one column access per ACT): define SAL_BK_CLOSED_PAGE_EN.
module sal_bank_fsm #(
  parameter int RA_W  = 16,
  parameter int CA_W  = 10,
  parameter int ID_W  = 4,
  parameter int LEN_W = 4,
  parameter int TW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  input  logic             req_wr_i,
  input  logic [RA_W-1:0]  req_ra_i,
  input  logic [CA_W-1:0]  req_ca_i,
  input  logic [ID_W-1:0]  req_id_i,
  input  logic [LEN_W-1:0] req_len_i,
  output logic             req_ready_o,
  input  logic             ref_req_i,
  output logic             ref_done_o,
  input  logic [TW-1:0]    t_rcd_m1_i,
  input  logic [TW-1:0]    t_rp_m1_i,
  input  logic [TW-1:0]    t_ras_m1_i,
  input  logic [TW-1:0]    t_rtp_m1_i,
  input  logic [TW-1:0]    t_wtp_m1_i,
  input  logic [TW-1:0]    t_rfc_m1_i,
  output logic             act_req_o,
  output logic             rd_req_o,
  output logic             wr_req_o,
  output logic             pre_req_o,
  output logic             ref_req_o,
  input  logic             act_gnt_i,
  input  logic             rd_gnt_i,
  input  logic             wr_gnt_i,
  input  logic             pre_gnt_i,
  input  logic             ref_gnt_i,
  output logic [RA_W-1:0]  ra_o,
  output logic [CA_W-1:0]  ca_o,
  output logic [ID_W-1:0]  id_o,
  output logic [LEN_W-1:0] len_o
);

  typedef enum logic [2:0] {
    CLOSED      = 3'd0,
    ACTIVATING  = 3'd1,
    OPEN        = 3'd2,
    PRECHARGING = 3'd3,
    REFRESHING  = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [RA_W-1:0] open_ra;
  logic [TW-1:0]   rcd_cnt, rp_cnt, ras_cnt, rtp_cnt, wtp_cnt, rfc_cnt;
  logic            close_pend;
  logic            row_hit, pre_ok;
  logic            act_fire, rd_fire, wr_fire, pre_fire, ref_fire;

  function automatic logic [TW-1:0] tick(input logic load, input logic [TW-1:0] m1,
                                         input logic [TW-1:0] cnt);
    if (load) return m1;
    if (cnt != '0) return cnt - TW'(1);
    return cnt;
  endfunction

  assign row_hit  = req_valid_i && (req_ra_i == open_ra);
  assign pre_ok   = (ras_cnt == '0) && (rtp_cnt == '0) && (wtp_cnt == '0);
  assign act_fire = act_req_o & act_gnt_i;
  assign rd_fire  = rd_req_o  & rd_gnt_i;
  assign wr_fire  = wr_req_o  & wr_gnt_i;
  assign pre_fire = pre_req_o & pre_gnt_i;
  assign ref_fire = ref_req_o & ref_gnt_i;

  assign req_ready_o = rd_fire | wr_fire;
  assign ra_o        = req_ra_i;
  assign ca_o        = req_ca_i;
  assign id_o        = req_id_i;
  assign len_o       = req_len_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcd_cnt <= '0;
      rp_cnt  <= '0;
      ras_cnt <= '0;
      rtp_cnt <= '0;
      wtp_cnt <= '0;
      rfc_cnt <= '0;
    end else begin
      rcd_cnt <= tick(act_fire, t_rcd_m1_i, rcd_cnt);
      ras_cnt <= tick(act_fire, t_ras_m1_i, ras_cnt);
      rp_cnt  <= tick(pre_fire, t_rp_m1_i,  rp_cnt);
      rtp_cnt <= tick(rd_fire,  t_rtp_m1_i, rtp_cnt);
      wtp_cnt <= tick(wr_fire,  t_wtp_m1_i, wtp_cnt);
      rfc_cnt <= tick(ref_fire, t_rfc_m1_i, rfc_cnt);
    end
  end

`ifdef SAL_BK_CLOSED_PAGE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     close_pend <= 1'b0;
    else if (pre_fire)           close_pend <= 1'b0;
    else if (rd_fire || wr_fire) close_pend <= 1'b1;
  end
`else
  assign close_pend = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLOSED;
      open_ra <= '0;
    end else begin
      state <= state_nxt;
      if (act_fire) open_ra <= req_ra_i;
    end
  end

  // ACTIVATING/PRECHARGING leave one cycle early (counter about to reach 0) and are
  // skipped for zero timings, so the dependent command is grantable exactly m1+1 cycles on.
  always_comb begin
    state_nxt = state;
    case (state)
      CLOSED: begin
        if (ref_fire)      state_nxt = REFRESHING;
        else if (act_fire) state_nxt = (t_rcd_m1_i == '0) ? OPEN : ACTIVATING;
      end
      ACTIVATING:  if (rcd_cnt <= TW'(1)) state_nxt = OPEN;
      OPEN:        if (pre_fire) state_nxt = (t_rp_m1_i == '0) ? CLOSED : PRECHARGING;
      PRECHARGING: if (rp_cnt <= TW'(1)) state_nxt = CLOSED;
      REFRESHING:  if (rfc_cnt == '0) state_nxt = CLOSED;
      default:     state_nxt = CLOSED;
    endcase
  end

  always_comb begin
    act_req_o  = 1'b0;
    rd_req_o   = 1'b0;
    wr_req_o   = 1'b0;
    pre_req_o  = 1'b0;
    ref_req_o  = 1'b0;
    ref_done_o = 1'b0;
    if (!rst) begin
      case (state)
        CLOSED: begin
          if (ref_req_i)        ref_req_o = 1'b1;
          else if (req_valid_i) act_req_o = 1'b1;
        end
        OPEN: begin
          if (row_hit && !ref_req_i && !close_pend) begin
            wr_req_o = req_wr_i;
            rd_req_o = !req_wr_i;
          end else if ((ref_req_i || req_valid_i || close_pend) && pre_ok) begin
            pre_req_o = 1'b1;
          end
        end
        REFRESHING: ref_done_o = (rfc_cnt == '0);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sal_bank_fsm.sv
// tb/tb_sal_bank_fsm.sv - bench for sal_bank_fsm: vector table, corner sequences, random vs timestamp model
module tb_sal_bank_fsm;
  localparam int RA_W = 16, CA_W = 10, ID_W = 4, LEN_W = 4, TW = 8;
`ifdef SAL_BK_CLOSED_PAGE_EN
  localparam bit CLOSED_PAGE = 1'b1;
`else
  localparam bit CLOSED_PAGE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid_i = 1'b0, req_wr_i = 1'b0, ref_req_i = 1'b0;
  logic [RA_W-1:0] req_ra_i = '0;
  logic [CA_W-1:0] req_ca_i = '0;
  logic [ID_W-1:0] req_id_i = '0;
  logic [LEN_W-1:0] req_len_i = '0;
  logic [TW-1:0] t_rcd_m1_i, t_rp_m1_i, t_ras_m1_i, t_rtp_m1_i, t_wtp_m1_i, t_rfc_m1_i;
  logic act_gnt_i = 1'b0, rd_gnt_i = 1'b0, wr_gnt_i = 1'b0, pre_gnt_i = 1'b0, ref_gnt_i = 1'b0;
  logic req_ready_o, ref_done_o, act_req_o, rd_req_o, wr_req_o, pre_req_o, ref_req_o;
  logic [RA_W-1:0] ra_o;
  logic [CA_W-1:0] ca_o;
  logic [ID_W-1:0] id_o;
  logic [LEN_W-1:0] len_o;

  always #5 clk = ~clk;

  sal_bank_fsm dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_wr_i(req_wr_i), .req_ra_i(req_ra_i), .req_ca_i(req_ca_i),
    .req_id_i(req_id_i), .req_len_i(req_len_i), .req_ready_o(req_ready_o),
    .ref_req_i(ref_req_i), .ref_done_o(ref_done_o),
    .t_rcd_m1_i(t_rcd_m1_i), .t_rp_m1_i(t_rp_m1_i), .t_ras_m1_i(t_ras_m1_i),
    .t_rtp_m1_i(t_rtp_m1_i), .t_wtp_m1_i(t_wtp_m1_i), .t_rfc_m1_i(t_rfc_m1_i),
    .act_req_o(act_req_o), .rd_req_o(rd_req_o), .wr_req_o(wr_req_o),
    .pre_req_o(pre_req_o), .ref_req_o(ref_req_o),
    .act_gnt_i(act_gnt_i), .rd_gnt_i(rd_gnt_i), .wr_gnt_i(wr_gnt_i),
    .pre_gnt_i(pre_gnt_i), .ref_gnt_i(ref_gnt_i),
    .ra_o(ra_o), .ca_o(ca_o), .id_o(id_o), .len_o(len_o)
  );

  // {act, rd, wr, pre, ref, ref_done, req_ready}
  logic [6:0] obs;
  assign obs = {act_req_o, rd_req_o, wr_req_o, pre_req_o, ref_req_o, ref_done_o, req_ready_o};

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic set_gnt(input logic [4:0] g);
    {act_gnt_i, rd_gnt_i, wr_gnt_i, pre_gnt_i, ref_gnt_i} = g;
  endtask

  int tm_rcd, tm_rp, tm_ras, tm_rtp, tm_wtp, tm_rfc;
  task automatic set_timing(input int rcd, input int rp, input int ras, input int rtp,
                            input int wtp, input int rfc);
    tm_rcd = rcd; tm_rp = rp; tm_ras = ras; tm_rtp = rtp; tm_wtp = wtp; tm_rfc = rfc;
    t_rcd_m1_i = TW'(rcd); t_rp_m1_i = TW'(rp); t_ras_m1_i = TW'(ras);
    t_rtp_m1_i = TW'(rtp); t_wtp_m1_i = TW'(wtp); t_rfc_m1_i = TW'(rfc);
  endtask

  task automatic set_req(input logic v, input logic wr, input logic [RA_W-1:0] ra);
    req_valid_i = v; req_wr_i = wr; req_ra_i = ra;
    req_ca_i = CA_W'($urandom); req_id_i = ID_W'($urandom); req_len_i = LEN_W'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_gnt(5'b0);
    #1;
    check("reset_outs", obs, 7'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model: bank status plus timestamps of the last grant of each command.
  int cyc, t_act, t_pre, t_rd, t_wr, t_ref;
  bit m_open, m_refr, m_cp;
  logic [RA_W-1:0] m_row;
  logic [4:0] e_req;
  logic e_done, e_ready;

  task automatic model_reset();
    cyc = 0; t_act = -1000; t_pre = -1000; t_rd = -1000; t_wr = -1000; t_ref = -1000;
    m_open = 0; m_refr = 0; m_cp = 0; m_row = '0;
  endtask

  task automatic model_eval();
    bit hit;
    e_req = '0;
    e_done = 1'b0;
    if (m_refr) begin
      e_done = (cyc == t_ref + tm_rfc + 1);
    end else if (!m_open) begin
      if (cyc >= t_pre + tm_rp + 1) begin
        if (ref_req_i) e_req = 5'b00001;
        else if (req_valid_i) e_req = 5'b10000;
      end
    end else if (cyc >= t_act + tm_rcd + 1) begin
      hit = req_valid_i && (req_ra_i == m_row);
      if (hit && !ref_req_i && !m_cp) e_req = req_wr_i ? 5'b00100 : 5'b01000;
      else if ((ref_req_i || req_valid_i || m_cp) && cyc >= t_act + tm_ras + 1 &&
               cyc >= t_rd + tm_rtp + 1 && cyc >= t_wr + tm_wtp + 1)
        e_req = 5'b00010;
    end
  endtask

  task automatic model_update(input logic [4:0] g);
    logic [4:0] f;
    f = e_req & g;
    if (f[4]) begin m_open = 1; m_row = req_ra_i; t_act = cyc; end
    if (f[3]) begin t_rd = cyc; m_cp = CLOSED_PAGE; end
    if (f[2]) begin t_wr = cyc; m_cp = CLOSED_PAGE; end
    if (f[1]) begin m_open = 0; m_cp = 0; t_pre = cyc; end
    if (f[0]) begin m_refr = 1; t_ref = cyc; end
    if (e_done) m_refr = 0;
    cyc++;
  endtask

  typedef struct {
    logic v; logic wr; logic [RA_W-1:0] ra; logic rf; logic [4:0] g; logic [6:0] exp;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic v, input logic wr, input int ra, input logic rf,
                     input logic [4:0] g, input logic [6:0] exp);
    vec_t e;
    e.v = v; e.wr = wr; e.ra = RA_W'(ra); e.rf = rf; e.g = g; e.exp = exp;
    vq.push_back(e);
  endtask

  logic [RA_W-1:0] ra_pool [3];
  logic [4:0] g;
  int r, first, stray;
  bit consumed, done_seen;

  initial begin
    ra_pool[0] = 16'd5; ra_pool[1] = 16'd7; ra_pool[2] = 16'd9;
    set_timing(2, 2, 2, 2, 2, 2);
    set_req(1, 0, 5);
    do_reset();

`ifndef SAL_BK_CLOSED_PAGE_EN
    // all _m1 = 2: cold read, write hit streak, miss precharge, refresh, re-activate
    add(1,0,5,0,5'b10000,7'b1000000); add(1,0,5,0,5'b00000,7'b0000000);
    add(1,0,5,0,5'b00000,7'b0000000); add(1,0,5,0,5'b01000,7'b0100001);
    add(1,1,5,0,5'b00000,7'b0010000); add(1,1,5,0,5'b00100,7'b0010001);
    add(1,1,5,0,5'b00100,7'b0010001); add(1,0,7,0,5'b00010,7'b0000000);
    add(1,0,7,0,5'b00000,7'b0000000); add(1,0,7,0,5'b00000,7'b0001000);
    add(1,0,7,0,5'b00010,7'b0001000); add(1,0,7,0,5'b00000,7'b0000000);
    add(1,0,7,0,5'b00000,7'b0000000); add(1,0,7,1,5'b10000,7'b0000100);
    add(1,0,7,1,5'b00001,7'b0000100); add(1,0,7,1,5'b00000,7'b0000000);
    add(1,0,7,1,5'b00000,7'b0000000); add(1,0,7,1,5'b00000,7'b0000010);
    add(1,0,7,0,5'b00000,7'b1000000);
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      set_req(vq[i].v, vq[i].wr, vq[i].ra);
      ref_req_i = vq[i].rf;
      set_gnt(vq[i].g);
      #2;
      check($sformatf("vec%0d", i), obs, vq[i].exp);
      check($sformatf("vec%0d_pass", i), {ra_o, ca_o, id_o, len_o},
            {req_ra_i, req_ca_i, req_id_i, req_len_i});
    end
    @(negedge clk);
    set_gnt(5'b0);
    ref_req_i = 1'b0;
`endif

    // grant withholding
    do_reset();
    set_req(1, 0, 5);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #2;
      check($sformatf("withhold%0d", i), obs, 7'b1000000);
    end

    // async reset while ACTIVATING
    set_timing(3, 3, 3, 3, 3, 3);
    do_reset();
    set_req(1, 0, 5);
    @(negedge clk); set_gnt(5'b10000); #2;
    check("actrst_act", obs, 7'b1000000);
    @(negedge clk); set_gnt(5'b0); #2;
    check("actrst_activating", obs, 7'b0);
    rst = 1'b1; #1;
    check("actrst_immediate", obs, 7'b0);
    @(negedge clk); set_gnt(5'b10000); #2;
    check("actrst_held", obs, 7'b0);
    @(negedge clk); rst = 1'b0; set_gnt(5'b0); #2;
    check("actrst_closed", obs, 7'b1000000);

    // row miss: pre gated by t_ras (10 after ACT) and t_wtp (5 after WR)
    set_timing(0, 0, 9, 0, 4, 0);
    do_reset();
    set_req(1, 1, 5);
    @(negedge clk); set_gnt(5'b10000); #2;
    check("miss_act0", obs, 7'b1000000);
    @(negedge clk); set_gnt(5'b00100); #2;
    check("miss_wr", obs, 7'b0010001);
    @(negedge clk); set_gnt(5'b0); set_req(1, 0, 7);
    first = -1;
    stray = 0;
    for (int k = 2; k < 40; k++) begin
      if (k > 2) @(negedge clk);
      #2;
      if (rd_req_o || act_req_o || wr_req_o) stray++;
      if (pre_req_o) begin
        first = k;
        set_gnt(5'b00010);
        break;
      end
    end
    check("miss_pre_cycle", first, 10);
    check("miss_no_stray", stray, 0);
    @(negedge clk); set_gnt(5'b0); #2;
    check("miss_act7", obs, 7'b1000000);
    check("miss_act7_ra", ra_o, 16'd7);

    // randomized traffic against the timestamp model
    for (int seg = 0; seg < 4; seg++) begin
      set_timing($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 9),
                 $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3));
      do_reset();
      req_valid_i = 1'b0;
      ref_req_i = 1'b0;
      model_reset();
      consumed = 0;
      done_seen = 0;
      for (int c = 0; c < 700; c++) begin
        @(negedge clk);
        if (consumed) req_valid_i = 1'b0;
        if (done_seen) ref_req_i = 1'b0;
        if (!req_valid_i && $urandom_range(0, 2) != 0)
          set_req(1'b1, 1'($urandom_range(0, 1)), ra_pool[$urandom_range(0, 2)]);
        if (!ref_req_i && !done_seen && $urandom_range(0, 59) == 0) ref_req_i = 1'b1;
        model_eval();
        r = $urandom_range(0, 9);
        if (r < 5) g = e_req;
        else if (r < 7) g = 5'b1 << $urandom_range(0, 4);
        else g = 5'b0;
        set_gnt(g);
        e_ready = |(e_req[3:2] & g[3:2]);
        #2;
        check("rand_outs", obs, {e_req, e_done, e_ready});
        check("rand_pass", {ra_o, ca_o, id_o, len_o}, {req_ra_i, req_ca_i, req_id_i, req_len_i});
        consumed = e_ready;
        done_seen = e_done;
        model_update(g);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
